// File: rtl/morse_pkg.sv
// Shared definitions for the Morse SOS transmitter/receiver pair:
// FSM encodings, the SOS symbol pattern and default unit counts.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // First symbol lands in the MSB: S O S = dot dot dot, dash dash dash, dot dot dot.
  localparam logic [8:0]  SOS_PATTERN    = 9'b000111000;
  localparam logic [3:0]  SOS_LEN        = 4'd9;
  localparam logic [3:0]  SYM_CNT_MAX    = 4'd10;

  // 250 ms unit at 50 MHz.
  localparam logic [23:0] T_UNIT_DEF     = 24'd12_499_999;
  localparam logic [4:0]  DOT_MAX_DEF    = 5'd7;
  localparam logic [4:0]  DASH_MAX_DEF   = 5'd15;
  localparam logic [4:0]  WORD_GAP_DEF   = 5'd8;
  localparam logic [4:0]  UNIT_CNT_MAX   = 5'd31;

  // Transmitter timing in units, kept here so both sides agree.
  localparam logic [4:0]  TX_DOT_UNITS   = 5'd4;
  localparam logic [4:0]  TX_DASH_UNITS  = 5'd12;
  localparam logic [4:0]  TX_SPACE_UNITS = 5'd2;

  function automatic logic [4:0] unit_sat_inc(input logic [4:0] v);
    return (v == UNIT_CNT_MAX) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Line synchronizer, edge detector and unit timer for the Morse receiver.
// unit_cnt_o counts whole units since the last edge or clear, saturating at 31.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter logic [23:0] T_UNIT = T_UNIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pin_i,
  input  logic       clr_i,
  output logic       rise_o,
  output logic       fall_o,
  output logic [4:0] unit_cnt_o
);

  logic        sync1_q;
  logic        pin_s_q;
  logic        pin_d_q;
  logic [23:0] cyc_q, cyc_d;
  logic [4:0]  unit_q, unit_d;

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      pin_s_q <= 1'b0;
      pin_d_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      pin_s_q <= sync1_q;
      pin_d_q <= pin_s_q;
    end
  end

  assign rise_o = pin_s_q & ~pin_d_q;
  assign fall_o = ~pin_s_q & pin_d_q;

  // Cycle counter wraps at T_UNIT and bumps the saturating unit count.
  always_comb begin
    cyc_d  = cyc_q + 24'd1;
    unit_d = unit_q;
    if (rise_o || fall_o || clr_i) begin
      cyc_d  = '0;
      unit_d = '0;
    end else if (cyc_q == T_UNIT) begin
      cyc_d  = '0;
      unit_d = unit_sat_inc(unit_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      unit_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      unit_q <= unit_d;
    end
  end

  assign unit_cnt_o = unit_q;

endmodule

// File: rtl/morse_sos_detect.sv
// Morse SOS receiver: classifies marks as dot/dash, collects one word and
// flags "... --- ..." (SOS_Det) or a malformed word (Err).
// Optional feature: define SOS_LATCH_EN to add Led_Out, a sticky SOS indicator.
//
// state | meaning
// IDLE  | waiting for the first mark of a word
// MARK  | line high, measuring mark length
// GAP   | line low inside a word, waiting for next mark or word gap
module morse_sos_detect
  import morse_pkg::*;
#(
  parameter logic [23:0] T_UNIT   = T_UNIT_DEF,
  parameter logic [4:0]  DOT_MAX  = DOT_MAX_DEF,
  parameter logic [4:0]  DASH_MAX = DASH_MAX_DEF,
  parameter logic [4:0]  WORD_GAP = WORD_GAP_DEF
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Det_En,
  input  logic Pin_In,
  output logic Sym_Valid,
  output logic Sym_Dash,
  output logic SOS_Det,
  output logic Err
`ifdef SOS_LATCH_EN
  ,
  output logic Led_Out
`endif
);

  state_e     state_q, state_d;
  logic [8:0] sym_q, sym_d;
  logic [3:0] cnt_q, cnt_d;
  logic       werr_q, werr_d;
  logic       dash_q, dash_d;
  logic       sym_valid;
  logic       sos_det;
  logic       word_err;
  logic       rise, fall;
  logic [4:0] unit_cnt;
  logic       timer_clr;

  // Restarting the timer on every state change makes each state measure from its own entry.
  assign timer_clr = (state_d != state_q) || !Det_En;

  morse_unit_timer #(
    .T_UNIT(T_UNIT)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST_n),
    .pin_i     (Pin_In),
    .clr_i     (timer_clr),
    .rise_o    (rise),
    .fall_o    (fall),
    .unit_cnt_o(unit_cnt)
  );

  // Next-state, symbol collection and word evaluation.
  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    cnt_d     = cnt_q;
    werr_d    = werr_q;
    dash_d    = dash_q;
    sym_valid = 1'b0;
    sos_det   = 1'b0;
    word_err  = 1'b0;
    if (!Det_En) begin
      state_d = ST_IDLE;
      sym_d   = '0;
      cnt_d   = '0;
      werr_d  = 1'b0;
      dash_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_MARK;
            sym_d   = '0;
            cnt_d   = '0;
            werr_d  = 1'b0;
          end
        end
        ST_MARK: begin
          if (fall) begin
            state_d = ST_GAP;
            // unit_cnt == 0 is a glitch and is dropped silently.
            if (unit_cnt != 5'd0 && unit_cnt <= DASH_MAX) begin
              sym_valid = 1'b1;
              dash_d    = (unit_cnt > DOT_MAX);
              sym_d     = {sym_q[7:0], dash_d};
              cnt_d     = (cnt_q == SYM_CNT_MAX) ? cnt_q : cnt_q + 4'd1;
            end else if (unit_cnt > DASH_MAX) begin
              werr_d = 1'b1;
            end
          end
        end
        ST_GAP: begin
          // A new mark wins over a coincident word-gap expiry so no edge is lost.
          if (rise) begin
            state_d = ST_MARK;
          end else if (unit_cnt == WORD_GAP) begin
            state_d = ST_IDLE;
            if (cnt_q == SOS_LEN && sym_q == SOS_PATTERN && !werr_q) begin
              sos_det = 1'b1;
            end else if (cnt_q != 4'd0 || werr_q) begin
              word_err = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and word registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
      cnt_q   <= '0;
      werr_q  <= 1'b0;
      dash_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      werr_q  <= werr_d;
      dash_q  <= dash_d;
    end
  end

  assign Sym_Valid = sym_valid;
  assign Sym_Dash  = sym_valid ? dash_d : dash_q;
  assign SOS_Det   = sos_det;
  assign Err       = word_err;

`ifdef SOS_LATCH_EN
  logic led_q;

  // Sticky SOS indicator; only disabling the detector or reset clears it.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      led_q <= 1'b0;
    end else if (!Det_En) begin
      led_q <= 1'b0;
    end else if (sos_det) begin
      led_q <= 1'b1;
    end
  end

  assign Led_Out = led_q;
`endif

endmodule

// File: tb/tb_morse_sos_detect.sv
// Directed bench for morse_sos_detect with T_UNIT = 9 (10 cycles per unit).
module tb_morse_sos_detect;

  logic CLK = 1'b0;
  logic RST_n;
  logic Det_En;
  logic Pin_In;
  logic Sym_Valid, Sym_Dash, SOS_Det, Err;
`ifdef SOS_LATCH_EN
  logic Led_Out;
`endif

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int nsym, nsos, nerr, nboth;
  int sos_cyc, fall_cyc;
  logic [8:0] pat;

  always #5 CLK = ~CLK;

  morse_sos_detect #(
    .T_UNIT  (24'd9),
    .DOT_MAX (5'd7),
    .DASH_MAX(5'd15),
    .WORD_GAP(5'd8)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .Det_En   (Det_En),
    .Pin_In   (Pin_In),
    .Sym_Valid(Sym_Valid),
    .Sym_Dash (Sym_Dash),
    .SOS_Det  (SOS_Det),
    .Err      (Err)
`ifdef SOS_LATCH_EN
    ,
    .Led_Out  (Led_Out)
`endif
  );

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (Sym_Valid) begin
      nsym = nsym + 1;
      pat  = {pat[7:0], Sym_Dash};
    end
    if (SOS_Det) begin
      nsos    = nsos + 1;
      sos_cyc = cyc;
    end
    if (Err) nerr = nerr + 1;
    if (SOS_Det && Err) nboth = nboth + 1;
  end

  task automatic clear_counts();
    nsym    = 0;
    nsos    = 0;
    nerr    = 0;
    pat     = '0;
    sos_cyc = 0;
  endtask

  // Hold the line at v for n cycles; returns just after a rising edge.
  task automatic hold(input logic v, input int n);
    Pin_In = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_mark(input int len);
    hold(1'b1, len);
    fall_cyc = cyc;
    hold(1'b0, 20);
  endtask

  task automatic send_sym(input bit dash);
    send_mark(dash ? 120 : 40);
  endtask

  task automatic send_s();
    for (int i = 0; i < 3; i++) send_sym(1'b0);
  endtask

  task automatic send_o();
    for (int i = 0; i < 3; i++) send_sym(1'b1);
  endtask

  task automatic send_sos();
    send_s();
    send_o();
    send_s();
  endtask

  task automatic test_reset();
    RST_n  = 1'b0;
    Det_En = 1'b1;
    Pin_In = 1'b0;
    nboth  = 0;
    clear_counts();
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (Sym_Valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid got %b want 0", Sym_Valid); end
    checks++; if (Sym_Dash !== 1'b0) begin errors++; $display("FAIL reset_sym_dash got %b want 0", Sym_Dash); end
    checks++; if (SOS_Det !== 1'b0) begin errors++; $display("FAIL reset_sos_det got %b want 0", SOS_Det); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", Err); end
`ifdef SOS_LATCH_EN
    checks++; if (Led_Out !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", Led_Out); end
`endif
    RST_n = 1'b1;
    hold(1'b0, 10);
  endtask

  // Word ends 80 cycles after the synchronized fall, which trails the pin by 3 cycles.
  task automatic test_clean_sos();
    int lat;
    clear_counts();
    send_sos();
    hold(1'b0, 100);
    lat = sos_cyc - fall_cyc;
    checks++; if (nsym !== 9) begin errors++; $display("FAIL clean_nsym got %0d want 9", nsym); end
    checks++; if (pat !== 9'b000111000) begin errors++; $display("FAIL clean_pattern got %b want 000111000", pat); end
    checks++; if (nsos !== 1) begin errors++; $display("FAIL clean_nsos got %0d want 1", nsos); end
    checks++; if (lat < 80 || lat > 86) begin errors++; $display("FAIL clean_latency got %0d want 80..86", lat); end
    checks++; if (nerr !== 0) begin errors++; $display("FAIL clean_nerr got %0d want 0", nerr); end
  endtask

  task automatic test_dots_only();
    clear_counts();
    send_s();
    hold(1'b0, 100);
    checks++; if (nsym !== 3) begin errors++; $display("FAIL dots_nsym got %0d want 3", nsym); end
    checks++; if (nerr !== 1) begin errors++; $display("FAIL dots_nerr got %0d want 1", nerr); end
    checks++; if (nsos !== 0) begin errors++; $display("FAIL dots_nsos got %0d want 0", nsos); end
  endtask

  task automatic test_glitch();
    clear_counts();
    send_s();
    send_mark(5);
    send_o();
    send_s();
    hold(1'b0, 100);
    checks++; if (nsym !== 9) begin errors++; $display("FAIL glitch_nsym got %0d want 9", nsym); end
    checks++; if (nsos !== 1) begin errors++; $display("FAIL glitch_nsos got %0d want 1", nsos); end
    checks++; if (nerr !== 0) begin errors++; $display("FAIL glitch_nerr got %0d want 0", nerr); end
  endtask

  task automatic test_long_mark();
    clear_counts();
    send_s();
    send_sym(1'b1);
    send_mark(170);
    send_sym(1'b1);
    send_s();
    hold(1'b0, 100);
    checks++; if (nsym !== 8) begin errors++; $display("FAIL long_nsym got %0d want 8", nsym); end
    checks++; if (nerr !== 1) begin errors++; $display("FAIL long_nerr got %0d want 1", nerr); end
    checks++; if (nsos !== 0) begin errors++; $display("FAIL long_nsos got %0d want 0", nsos); end
  endtask

  task automatic test_det_en();
    clear_counts();
    send_s();
    send_sym(1'b1);
    send_sym(1'b1);
    Det_En = 1'b0;
    hold(1'b0, 10);
    Det_En = 1'b1;
    hold(1'b0, 100);
    checks++; if (nsym !== 5) begin errors++; $display("FAIL deten_partial_nsym got %0d want 5", nsym); end
    checks++; if (nsos !== 0) begin errors++; $display("FAIL deten_partial_nsos got %0d want 0", nsos); end
    checks++; if (nerr !== 0) begin errors++; $display("FAIL deten_partial_nerr got %0d want 0", nerr); end
    clear_counts();
    send_sos();
    hold(1'b0, 100);
    checks++; if (nsos !== 1) begin errors++; $display("FAIL deten_full_nsos got %0d want 1", nsos); end
    checks++; if (nerr !== 0) begin errors++; $display("FAIL deten_full_nerr got %0d want 0", nerr); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    send_s();
    hold(1'b1, 60);
    RST_n = 1'b0;
    hold(1'b1, 5);
    hold(1'b0, 15);
    checks++; if (Sym_Valid !== 1'b0) begin errors++; $display("FAIL midrst_sym_valid got %b want 0", Sym_Valid); end
    checks++; if (Sym_Dash !== 1'b0) begin errors++; $display("FAIL midrst_sym_dash got %b want 0", Sym_Dash); end
    checks++; if (SOS_Det !== 1'b0) begin errors++; $display("FAIL midrst_sos_det got %b want 0", SOS_Det); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", Err); end
    RST_n = 1'b1;
    hold(1'b0, 10);
    clear_counts();
    send_sos();
    hold(1'b0, 100);
    checks++; if (nsos !== 1) begin errors++; $display("FAIL midrst_nsos got %0d want 1", nsos); end
    checks++; if (nerr !== 0) begin errors++; $display("FAIL midrst_nerr got %0d want 0", nerr); end
`ifdef SOS_LATCH_EN
    checks++; if (Led_Out !== 1'b1) begin errors++; $display("FAIL led_set got %b want 1", Led_Out); end
    Det_En = 1'b0;
    hold(1'b0, 2);
    checks++; if (Led_Out !== 1'b0) begin errors++; $display("FAIL led_clear got %b want 0", Led_Out); end
    Det_En = 1'b1;
`endif
  endtask

  task automatic test_exclusive();
    checks++; if (nboth !== 0) begin errors++; $display("FAIL sos_err_overlap got %0d want 0", nboth); end
  endtask

  initial begin
    test_reset();
    test_clean_sos();
    test_dots_only();
    test_glitch();
    test_long_mark();
    test_det_en();
    test_reset_mid();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
